// File: rtl/image_stream_ctrl.sv
// Frame sequencer: reads a 1-cycle-latency pixel source in raster order and
// emits the frame as a valid/ready stream with coordinates and frame markers.
// rd_en and the markers are combinational from registered state (rd_en also
// sees m_ready through the pop term) so a 2-entry buffer sustains one pixel
// per cycle. In continuous mode with m_ready held high, the first pixel of
// the next frame is valid GAP_CYCLES+4 cycles after the m_eof handshake.
module image_stream_ctrl #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned GAP_CYCLES = 16,
    parameter bit          NEGA       = 1'b0,
    localparam int unsigned PIXELS    = IMG_WIDTH * IMG_HEIGHT,
    localparam int unsigned AW        = $clog2(PIXELS),
    localparam int unsigned HW        = $clog2(IMG_WIDTH),
    localparam int unsigned VW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [HW-1:0]         m_hcount,
    output logic [VW-1:0]         m_vcount,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [AW-1:0]         addr_q;
    logic                  stop_req_q;
    logic [GW-1:0]         gap_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] mem0_q;
    logic [DATA_WIDTH-1:0] mem1_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [HW-1:0]         h_q;
    logic [VW-1:0]         v_q;
    logic [15:0]           frame_q;

    logic                  pop;
    logic [2:0]            pending;
    logic                  issue;
    logic                  last_issue;
    logic                  stop_any;
    logic                  h_last;
    logic                  v_last;

    // Handshake, outstanding-pixel accounting and read issue decision
    assign m_valid    = (count_q != 2'd0);
    assign pop        = m_valid & m_ready;
    assign pending    = 3'(count_q) + 3'(inflight_q);
    assign issue      = (state_q == S_RUN) && ((pending - 3'(pop)) < 3'd2);
    assign last_issue = issue && (addr_q == AW'(PIXELS - 1));
    assign stop_any   = stop_req_q | stop;

    assign h_last     = (h_q == HW'(IMG_WIDTH - 1));
    assign v_last     = (v_q == VW'(IMG_HEIGHT - 1));

    assign rd_en      = issue;
    assign rd_addr    = addr_q;
    assign m_data     = rd_ptr_q ? mem1_q : mem0_q;
    assign m_hcount   = h_q;
    assign m_vcount   = v_q;
    assign m_sof      = m_valid && (h_q == '0) && (v_q == '0);
    assign m_eol      = m_valid && h_last;
    assign m_eof      = m_valid && h_last && v_last;
    assign busy       = (state_q != S_IDLE);
    assign frame_cnt  = frame_q;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pending == 3'd0) begin
                    if (stop_any || !continuous) begin
                        state_d = S_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (stop_any) begin
                    state_d = S_IDLE;
                end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read address, stop request, gap timer and in-flight tracking
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q     <= '0;
            stop_req_q <= 1'b0;
            gap_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                addr_q <= last_issue ? '0 : addr_q + 1'b1;
            end
            if (state_q == S_IDLE) begin
                stop_req_q <= start & stop;
            end else if (stop) begin
                stop_req_q <= 1'b1;
            end
            if (state_q == S_GAP) begin
                gap_q <= gap_q + 1'b1;
            end else begin
                gap_q <= '0;
            end
        end
    end

    // Two-entry output buffer; source data is optionally inverted on write
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (inflight_q) begin
                if (wr_ptr_q) begin
                    mem1_q <= NEGA ? ~rd_data : rd_data;
                end else begin
                    mem0_q <= NEGA ? ~rd_data : rd_data;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(inflight_q) - 2'(pop);
        end
    end

    // Output raster coordinates and completed-frame counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= 16'd0;
        end else if (pop) begin
            if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? '0 : v_q + 1'b1;
                if (v_last) begin
                    frame_q <= frame_q + 16'd1;
                end
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_image_stream_ctrl.sv
// Scoreboard bench for image_stream_ctrl with a 4x3 frame and GAP_CYCLES=2.
// A second instance with NEGA=1 shares all inputs and must show ~ROM data.
// Frame-to-frame latency: first pixel of the next frame is valid
// GAP_CYCLES+4 = 6 cycles after the m_eof handshake.
module tb_image_stream_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] h;
        logic [1:0] v;
        logic       sof;
        logic       eol;
        logic       eof;
    } pix_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        stop;
    logic        continuous;
    logic        m_ready;

    logic        rd_en, rd_en2;
    logic [3:0]  rd_addr, rd_addr2;
    logic [7:0]  rd_data, rd_data2;
    logic        m_valid, m_valid2;
    logic [7:0]  m_data, m_data2;
    logic [1:0]  h, h2, v, v2;
    logic        sof, sof2, eol, eol2, eof, eof2;
    logic        busy, busy2;
    logic [15:0] fc, fc2;

    pix_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rd_count = 0;
    int   cyc = 0;
    int   eof_cyc = 0;
    bit   have_eof = 1'b0;
    bit   prev_sof = 1'b0;
    bit   ready_mode = 1'b0;
    int   ridx = 0;
    logic [15:0] rpat = 16'b1011_0010_0111_0100;

    image_stream_ctrl #(
        .IMG_WIDTH(4), .IMG_HEIGHT(3), .DATA_WIDTH(8), .GAP_CYCLES(2), .NEGA(1'b0)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .continuous(continuous),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_hcount(h), .m_vcount(v), .m_sof(sof), .m_eol(eol), .m_eof(eof),
        .busy(busy), .frame_cnt(fc)
    );

    image_stream_ctrl #(
        .IMG_WIDTH(4), .IMG_HEIGHT(3), .DATA_WIDTH(8), .GAP_CYCLES(2), .NEGA(1'b1)
    ) dut_n (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .continuous(continuous),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
        .m_hcount(h2), .m_vcount(v2), .m_sof(sof2), .m_eol(eol2), .m_eof(eof2),
        .busy(busy2), .frame_cnt(fc2)
    );

    always #5 clk = ~clk;

    // ROM[i] = i with one cycle of read latency, one per instance
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= 8'(rd_addr);
        if (rd_en2) rd_data2 <= 8'(rd_addr2);
    end

    // Downstream ready: either held by the stimulus or a fixed rotating pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                m_ready = rpat[ridx];
                ridx = (ridx + 1) % 16;
            end
        end
    end

    function automatic pix_t model(input int i);
        pix_t p;
        p.data = 8'(i);
        p.h    = 2'(i % 4);
        p.v    = 2'(i / 4);
        p.sof  = (i == 0);
        p.eol  = ((i % 4) == 3);
        p.eof  = (i == 11);
        return p;
    endfunction

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int i = 0; i < 12; i++)
                exp_q.push_back(model(i));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        step();
        n_rst = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) step();
        n_rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < budget);
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles, expected 0", tag, budget);
        end
    endtask

    task automatic wait_fc(input int val, input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (32'(fc) != val && k < budget);
        n_cmp++;
        if (32'(fc) != val) begin
            n_err++;
            $display("FAIL %s_fc_timeout: frame_cnt %0d expected %0d", tag, fc, val);
        end
    endtask

    task automatic wait_pix(input logic [1:0] hh, input logic [1:0] vv, input int budget,
                            input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_valid && h == hh && v == vv) && k < budget);
        n_cmp++;
        if (!(m_valid && h == hh && v == vv)) begin
            n_err++;
            $display("FAIL %s_pix_timeout: pixel (%0d,%0d) not seen, at (%0d,%0d) valid %0b",
                     tag, hh, vv, h, v, m_valid);
        end
    endtask

    // Monitor: compare every presented pixel against the scoreboard head
    always @(negedge clk) begin
        pix_t e;
        pix_t act;
        pix_t act2;
        pix_t exp2;
        bit   sof_v;
        cyc++;
        if (!n_rst) begin
            have_eof = 1'b0;
            prev_sof = 1'b0;
            rd_count = 0;
        end else begin
            if (rd_en) rd_count++;
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pixel: data %0h at (%0d,%0d), scoreboard empty",
                             m_data, h, v);
                end else begin
                    e    = exp_q[0];
                    act  = {m_data, h, v, sof, eol, eof};
                    n_cmp++;
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL pixel: got %0h expected %0h (data,h,v,sof,eol,eof)",
                                 act, e);
                    end
                    exp2 = e;
                    exp2.data = ~e.data;
                    act2 = {m_data2, h2, v2, sof2, eol2, eof2};
                    n_cmp++;
                    if (!m_valid2 || act2 !== exp2) begin
                        n_err++;
                        $display("FAIL nega_pixel: valid %0b got %0h expected %0h",
                                 m_valid2, act2, exp2);
                    end
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        if (e.eof) begin
                            have_eof = 1'b1;
                            eof_cyc  = cyc;
                        end
                    end
                end
            end
            sof_v = m_valid && sof;
            if (sof_v && !prev_sof && have_eof) begin
                n_cmp++;
                if (cyc - eof_cyc != 6) begin
                    n_err++;
                    $display("FAIL frame_gap: %0d cycles eof-to-sof, expected 6", cyc - eof_cyc);
                end
                have_eof = 1'b0;
            end
            prev_sof = sof_v;
        end
    end

    // Directed stimulus
    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_ctrl", 32'({rd_en, rd_addr, m_valid, busy}), 32'd0);
        chk("rst_pix", 32'({m_data, h, v, sof, eol, eof}), 32'd0);
        chk("rst_fc", 32'(fc), 32'd0);
        step();
        n_rst = 1'b1;

        // Single shot, full throughput, start latency
        continuous = 1'b0;
        push_frames(1);
        pulse_start();
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_rd", 32'({rd_en, rd_addr}), 32'h10);
        chk("start_valid_t1", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("start_valid_t2", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("start_valid_t3", 32'(m_valid), 32'd1);
        wait_idle(100, "single");
        chk("single_fc", 32'(fc), 32'd1);
        chk("single_fc_nega", 32'(fc2), 32'd1);
        chk("single_reads", 32'(rd_count), 32'd12);
        chk("single_drained", 32'(exp_q.size()), 32'd0);

        // Three continuous frames under backpressure, stop during frame 3
        do_reset();
        continuous = 1'b1;
        ready_mode = 1'b1;
        push_frames(3);
        pulse_start();
        wait_fc(2, 600, "bp");
        wait_pix(2'd1, 2'd0, 100, "bp");
        pulse_stop();
        wait_idle(300, "bp");
        ready_mode = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        chk("bp_fc", 32'(fc), 32'd3);
        chk("bp_reads", 32'(rd_count), 32'd36);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Stop in the middle of frame 2 lets it finish, no further reads
        do_reset();
        continuous = 1'b1;
        push_frames(2);
        pulse_start();
        wait_fc(1, 200, "stop");
        wait_pix(2'd1, 2'd1, 100, "stop");
        pulse_stop();
        wait_idle(200, "stop");
        chk("stop_fc", 32'(fc), 32'd2);
        chk("stop_drained", 32'(exp_q.size()), 32'd0);
        repeat (20) step();
        chk("stop_reads", 32'(rd_count), 32'd24);
        chk("stop_busy", 32'({busy, busy2}), 32'd0);

        // start+stop together gives one frame; start while busy is ignored
        do_reset();
        continuous = 1'b1;
        push_frames(1);
        step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        wait_pix(2'd2, 2'd1, 100, "one");
        pulse_start();
        wait_idle(200, "one");
        repeat (10) step();
        chk("one_fc", 32'(fc), 32'd1);
        chk("one_reads", 32'(rd_count), 32'd12);
        chk("one_busy", 32'(busy), 32'd0);
        chk("one_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset at pixel 5 clears everything, restart is clean
        do_reset();
        continuous = 1'b0;
        push_frames(1);
        pulse_start();
        wait_pix(2'd1, 2'd1, 100, "abort");
        #1;
        n_rst = 1'b0;
        #1;
        chk("abort_ctrl", 32'({rd_en, rd_addr, m_valid, busy}), 32'd0);
        chk("abort_pix", 32'({m_data, h, v, sof, eol, eof}), 32'd0);
        chk("abort_fc", 32'({fc, fc2}), 32'd0);
        exp_q.delete();
        repeat (2) step();
        n_rst = 1'b1;
        push_frames(1);
        pulse_start();
        wait_idle(100, "restart");
        chk("restart_fc", 32'(fc), 32'd1);
        chk("restart_reads", 32'(rd_count), 32'd12);
        chk("restart_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/image_stream_ctrl.md
# image_stream_ctrl

Frame sequencer for the camera/test-image path. It reads a ROM-backed image source with 1-cycle read latency by pixel address. It emits the frame as a valid/ready pixel stream with raster coordinates, start-of-frame, end-of-line and end-of-frame markers. It supports single-shot and continuous frame playback with an inter-frame gap, and tolerates arbitrary downstream backpressure without dropping or duplicating pixels.

## Interface
- IMG_WIDTH, 640, pixels per line (≥2)
- IMG_HEIGHT, 480, lines per frame (≥1)
- DATA_WIDTH, 8, pixel width
- GAP_CYCLES, 16, idle cycles between frames in continuous mode (0 allowed)
- NEGA, 0, 1 = output bitwise-inverted pixel data
- Address/count widths: $clog2(IMG_WIDTH*IMG_HEIGHT), $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT).

Ports (one clock `clk`; reset `n_rst` is asynchronous, active-low):
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin playback (sampled in IDLE only)
- stop  in  1  request halt at end of current frame
- continuous  in  1  1 = loop frames; sampled at each frame end
- rd_en  out  1  source read strobe
- rd_addr  out  $clog2(PIXELS)  pixel address, raster order
- rd_data  in  DATA_WIDTH  source data, valid the cycle after rd_en
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  pixel (inverted if NEGA)
- m_hcount  out  $clog2(IMG_WIDTH)  column of m_data
- m_vcount  out  $clog2(IMG_HEIGHT)  row of m_data
- m_sof  out  1  pixel (0,0)
- m_eol  out  1  column IMG_WIDTH-1
- m_eof  out  1  last pixel of frame
- busy  out  1  state ≠ IDLE
- frame_cnt  out  16  completed frames, wraps

## Operation
- States: IDLE, RUN, DRAIN, GAP.
- IDLE: start=1 → RUN, rd address counter ← 0, stop_req ← 0.
- RUN: issue rd_en with rd_addr = counter when pending − pop < 2. pending = FIFO occupancy + reads in flight. pop = m_valid & m_ready this cycle. Counter increments per issue. The issue of address PIXELS−1 → DRAIN.
- DRAIN: no reads. When pending = 0: if stop_req or !continuous → IDLE; else GAP_CYCLES=0 → RUN (addr 0); else → GAP.
- GAP: count GAP_CYCLES cycles, then → RUN with addr 0.
- Output: 2-entry FIFO. rd_data is written the cycle after rd_en. Head drives m_data/markers. Data is inverted at FIFO write when NEGA=1.
- Output coordinate counters advance only on handshake. hcount wraps at IMG_WIDTH−1 and increments vcount. vcount wraps at IMG_HEIGHT−1.
- m_sof/m_eol/m_eof are combinational from the output counters and qualified by m_valid.
- frame_cnt increments on handshake of the m_eof pixel.
- stop=1 in RUN/DRAIN/GAP sets stop_req. In GAP it → IDLE next cycle. stop in IDLE: no effect.
- start while busy: ignored. start & stop same cycle in IDLE: exactly one frame, then IDLE.
- m_valid, once high, holds with stable data/markers until m_ready.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE, FIFO empty, in-flight cleared.
  - rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_hcount=0, m_vcount=0.
  - m_sof/m_eol/m_eof=0, busy=0, frame_cnt=0.
- start at cycle T: busy=1 and rd_en=1 (addr 0) at T+1. m_valid=1 with pixel 0 at T+3.
- Steady state with m_ready=1: one pixel per cycle, no bubbles within a frame.
- m_ready low for N cycles: at most 2 pixels buffered. rd_en stalls. No loss or duplication.
- Continuous with m_ready=1: m_eof pixel accepted at cycle E → first pixel of next frame valid at E+GAP_CYCLES+3 (±1 per implementation, documented and fixed in the bench).
- Reset mid-frame: immediate abort. Next start begins at address 0, sof on first pixel.

## Test plan
- W=4,H=3,GAP=2, continuous=0, m_ready=1, pulse start → 12 pixels at ROM[0..11] in order. sof on pixel 0, eol on 3/7/11, eof on 11. frame_cnt=1, busy falls, then IDLE.
- Same with NEGA=1, ROM[i]=i → m_data = ~i (8'hFF, 8'hFE, …).
- Random m_ready (50%) over 3 continuous frames → 36 pixels, exact order, data stable while stalled. frame_cnt=3, gap ≥2 cycles between frames.
- continuous=1, stop pulsed mid-frame 2 → frame 2 completes fully, frame_cnt=2, IDLE, no frame-3 reads.
- start+stop same cycle, continuous=1 → exactly one frame. start pulsed while busy → no restart, counts unchanged.
- n_rst asserted at pixel 5 with m_valid=1 → all outputs zero immediately. Restart → pixel 0 with sof, frame_cnt counts from 0.
